// File: rtl/archie_pkg.sv
// Shared Archimedes SDRAM-side definitions: Wishbone constants, ROM base and the upload reader state type.
package archie_pkg;

  localparam logic [2:0]  WB_CTI_CLASSIC     = 3'b000;
  localparam logic [3:0]  WB_SEL_ALL         = 4'b1111;
  localparam logic [23:0] ROM_BASE_WORD      = 24'h100000;
  localparam logic [31:0] FETCH_TIMEOUT_DATA = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_FETCH_CUR = 2'd1,
    ST_FETCH_NXT = 2'd2,
    ST_HOLD      = 2'd3
  } rd_state_e;

  function automatic logic [15:0] pick_half(input logic [31:0] word, input logic hi);
    return hi ? word[31:16] : word[15:0];
  endfunction

endpackage

// File: rtl/ram_upload_reader_if.sv
// Classic Wishbone read port between the upload reader and the SDRAM bus mux.
interface ram_upload_reader_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [23:0] adr;
  logic [31:0] dat_i;
  logic        ack;

  modport master (output cyc, stb, we, sel, cti, adr, input dat_i, ack);
  modport slave  (input cyc, stb, we, sel, cti, adr, output dat_i, ack);
endinterface

// File: rtl/ram_upload_reader_wb_word_fetch.sv
// Single-request Wishbone read engine: holds stb until ack, gives up after TIMEOUT cycles with all-ones data.
module wb_word_fetch
  import archie_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [23:0] adr_in,
  input  logic        ack,
  input  logic [31:0] dat_in,
  output logic        cyc,
  output logic        stb,
  output logic [23:0] adr,
  output logic        busy,
  output logic        done,
  output logic        timed_out,
  output logic [31:0] dat_out
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic          stb_r;
  logic [23:0]   adr_r;
  logic [CW-1:0] cnt_r;
  logic          live_s;
  logic          expire_s;

  // An abort (session end) masks any ack, so a late ack can never complete a fetch.
  assign live_s    = stb_r && !abort;
  assign expire_s  = live_s && !ack && (cnt_r == CNT_LAST);
  assign done      = live_s && (ack || (cnt_r == CNT_LAST));
  assign timed_out = expire_s;
  assign dat_out   = ack ? dat_in : FETCH_TIMEOUT_DATA;

  assign cyc  = stb_r;
  assign stb  = stb_r;
  assign adr  = adr_r;
  assign busy = stb_r;

  // Request handshake, latched address and ack timeout counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stb_r <= 1'b0;
      adr_r <= 24'h000000;
      cnt_r <= '0;
    end else if (abort || done) begin
      stb_r <= 1'b0;
      cnt_r <= '0;
    end else if (start) begin
      stb_r <= 1'b1;
      adr_r <= adr_in;
      cnt_r <= '0;
    end else if (stb_r) begin
      cnt_r <= cnt_r + CW'(1'b1);
    end
  end

endmodule

// File: rtl/ram_upload_reader.sv
// Reads the SDRAM image region back over Wishbone and serves it as halfwords on the hps_io upload channel.
// A CUR/NXT word pair lets sequential reads cross word boundaries without stalling the HPS.
module ram_upload_reader
  import archie_pkg::*;
#(
  parameter logic [23:0] BASE_WORD = ROM_BASE_WORD,
  parameter int          SPAN_W    = 20,
  parameter int          TIMEOUT   = 255
) (
  input  logic                       clk_sys,
  input  logic                       reset_n,
  input  logic                       ioctl_upload,
  input  logic                       ioctl_rd,
  input  logic [24:0]                ioctl_addr,
  output logic [15:0]                ioctl_din,
  output logic                       ioctl_wait,
  output logic                       bus_own,
  output logic                       err,
  ram_upload_reader_if.master        wb
);

  rd_state_e         state_r;
  rd_state_e         state_nx_s;
  logic              upload_r;
  logic [31:0]       cur_dat_r;
  logic [31:0]       nxt_dat_r;
  logic [SPAN_W-1:0] cur_tag_r;
  logic [SPAN_W-1:0] nxt_tag_r;
  logic              cur_vld_r;
  logic              nxt_vld_r;
  logic [SPAN_W-1:0] fetch_word_r;
  logic [SPAN_W-1:0] fetch_word_nx_s;
  logic              err_r;
  logic              bus_own_r;

  logic [SPAN_W-1:0] req_word_s;
  logic              cur_hit_s;
  logic              nxt_hit_s;
  logic [23:0]       fetch_adr_s;
  logic              fetch_start_s;
  logic              fetch_abort_s;
  logic              fetch_busy_s;
  logic              fetch_done_s;
  logic              fetch_tout_s;
  logic [31:0]       fetch_dat_s;
  logic              load_cur_s;
  logic              load_nxt_s;
  logic              promote_s;
  logic              clr_vld_s;
  logic              clr_err_s;
  logic              unused_addr_s;

  assign req_word_s    = ioctl_addr[SPAN_W+1:2];
  assign unused_addr_s = ^{ioctl_addr[24:SPAN_W+2], ioctl_addr[0]};
  assign cur_hit_s     = cur_vld_r && (cur_tag_r == req_word_s);
  assign nxt_hit_s     = nxt_vld_r && (nxt_tag_r == req_word_s);
  assign fetch_adr_s   = BASE_WORD + 24'(fetch_word_r);
  assign fetch_abort_s = !ioctl_upload;

  wb_word_fetch #(
    .TIMEOUT (TIMEOUT)
  ) u_fetch (
    .clk       (clk_sys),
    .rst_n     (reset_n),
    .start     (fetch_start_s),
    .abort     (fetch_abort_s),
    .adr_in    (fetch_adr_s),
    .ack       (wb.ack),
    .dat_in    (wb.dat_i),
    .cyc       (wb.cyc),
    .stb       (wb.stb),
    .adr       (wb.adr),
    .busy      (fetch_busy_s),
    .done      (fetch_done_s),
    .timed_out (fetch_tout_s),
    .dat_out   (fetch_dat_s)
  );

  assign wb.we  = 1'b0;
  assign wb.sel = WB_SEL_ALL;
  assign wb.cti = WB_CTI_CLASSIC;

  assign ioctl_din  = pick_half(cur_dat_r, ioctl_addr[1]);
  assign ioctl_wait = !cur_hit_s || !ioctl_upload;
  assign bus_own    = bus_own_r;
  assign err        = err_r;

  // State register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state and buffer-control decode; a fetch is issued on the first idle cycle of a fetch state.
  always_comb begin
    state_nx_s      = state_r;
    fetch_word_nx_s = fetch_word_r;
    fetch_start_s   = 1'b0;
    load_cur_s      = 1'b0;
    load_nxt_s      = 1'b0;
    promote_s       = 1'b0;
    clr_vld_s       = 1'b0;
    clr_err_s       = 1'b0;
    if (!ioctl_upload) begin
      state_nx_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!upload_r) begin
            clr_vld_s       = 1'b1;
            clr_err_s       = 1'b1;
            fetch_word_nx_s = req_word_s;
            state_nx_s      = ST_FETCH_CUR;
          end else begin
            state_nx_s = ST_IDLE;
          end
        end
        ST_FETCH_CUR: begin
          if (fetch_done_s) begin
            load_cur_s      = 1'b1;
            fetch_word_nx_s = fetch_word_r + SPAN_W'(1'b1);
            state_nx_s      = ST_FETCH_NXT;
          end else if (!fetch_busy_s) begin
            fetch_start_s = 1'b1;
          end else begin
            state_nx_s = ST_FETCH_CUR;
          end
        end
        ST_FETCH_NXT: begin
          if (fetch_done_s) begin
            load_nxt_s = 1'b1;
            state_nx_s = ST_HOLD;
          end else if (!fetch_busy_s) begin
            fetch_start_s = 1'b1;
          end else begin
            state_nx_s = ST_FETCH_NXT;
          end
        end
        ST_HOLD: begin
          if ((ioctl_rd && ioctl_addr[1] && nxt_vld_r) || (nxt_hit_s && !cur_hit_s)) begin
            promote_s       = 1'b1;
            fetch_word_nx_s = nxt_tag_r + SPAN_W'(1'b1);
            state_nx_s      = ST_FETCH_NXT;
          end else if (!cur_hit_s) begin
            clr_vld_s       = 1'b1;
            fetch_word_nx_s = req_word_s;
            state_nx_s      = ST_FETCH_CUR;
          end else begin
            state_nx_s = ST_HOLD;
          end
        end
        default: begin
          state_nx_s = ST_IDLE;
        end
      endcase
    end
  end

  // Word buffer, tags, sticky error and bus ownership.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      upload_r     <= 1'b0;
      bus_own_r    <= 1'b0;
      err_r        <= 1'b0;
      fetch_word_r <= '0;
      cur_dat_r    <= 32'h0000_0000;
      nxt_dat_r    <= 32'h0000_0000;
      cur_tag_r    <= '0;
      nxt_tag_r    <= '0;
      cur_vld_r    <= 1'b0;
      nxt_vld_r    <= 1'b0;
    end else begin
      upload_r     <= ioctl_upload;
      bus_own_r    <= (state_nx_s != ST_IDLE);
      fetch_word_r <= fetch_word_nx_s;
      if (clr_err_s) begin
        err_r <= 1'b0;
      end else if (fetch_tout_s) begin
        err_r <= 1'b1;
      end
      if (clr_vld_s) begin
        cur_vld_r <= 1'b0;
        nxt_vld_r <= 1'b0;
      end else if (load_cur_s) begin
        cur_dat_r <= fetch_dat_s;
        cur_tag_r <= fetch_word_r;
        cur_vld_r <= 1'b1;
      end else if (load_nxt_s) begin
        nxt_dat_r <= fetch_dat_s;
        nxt_tag_r <= fetch_word_r;
        nxt_vld_r <= 1'b1;
      end else if (promote_s) begin
        cur_dat_r <= nxt_dat_r;
        cur_tag_r <= nxt_tag_r;
        cur_vld_r <= 1'b1;
        nxt_vld_r <= 1'b0;
      end
    end
  end

endmodule
